aes_inv_sub_bytes: RTL and testbench

Iterative InvSubBytes() unit for the AES-128 decryption datapath. It accepts a 128-bit state and substitutes every byte through the AES inverse S-box. It uses one shared 32-bit (4-byte) inverse S-box lane, one word per cycle over four cycles. It sits between InvShiftRows and AddRoundKey in the decrypt round loop and uses a valid/ready handshake on both sides.

---
 rtl/aes_inv_sub_bytes.sv | 146 ++++++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes.sv
// aes_inv_sub_bytes: iterative AES InvSubBytes, one 32-bit word per cycle over four cycles.
// Optional AES_INV_SUB_FWD_EN adds an encrypt input that switches the lane to the forward S-box.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// BUSY  | substituting word wcnt of the state register
// DONE  | out_valid high until out_ready
module aes_inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef AES_INV_SUB_FWD_EN
    input  logic         encrypt,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    // Row r holds entries 16r..16r+15, entry 0 sits in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

`ifdef AES_INV_SUB_FWD_EN
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic enc_q;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   wcnt;
    logic [127:0] data_q;
    logic [31:0]  word_in;
    logic [31:0]  word_out;

    function automatic logic [7:0] tbl_lookup(input logic [2047:0] tbl, input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return tbl[idx +: 8];
    endfunction

    always_comb begin
        word_in  = '0;
        word_out = '0;
        case (wcnt)
            2'd0:    word_in = data_q[127:96];
            2'd1:    word_in = data_q[95:64];
            2'd2:    word_in = data_q[63:32];
            default: word_in = data_q[31:0];
        endcase
        for (int i = 0; i < 4; i++) begin
`ifdef AES_INV_SUB_FWD_EN
            word_out[8*i +: 8] = enc_q ? tbl_lookup(FWD_SBOX, word_in[8*i +: 8])
                                       : tbl_lookup(INV_SBOX, word_in[8*i +: 8]);
`else
            word_out[8*i +: 8] = tbl_lookup(INV_SBOX, word_in[8*i +: 8]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= 2'd0;
            data_q    <= '0;
            out_valid <= 1'b0;
`ifdef AES_INV_SUB_FWD_EN
            enc_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_state;
                        wcnt   <= 2'd0;
                        state  <= BUSY;
`ifdef AES_INV_SUB_FWD_EN
                        enc_q  <= encrypt;
`endif
                    end
                end
                BUSY: begin
                    case (wcnt)
                        2'd0:    data_q[127:96] <= word_out;
                        2'd1:    data_q[95:64]  <= word_out;
                        2'd2:    data_q[63:32]  <= word_out;
                        default: data_q[31:0]   <= word_out;
                    endcase
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated with rst so the port reads 0 throughout reset, not just after an edge.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_state = data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Testbench for aes_inv_sub_bytes: S-box reference built from GF(2^8) inversion plus the affine map.
// Compile with +define+AES_INV_SUB_FWD_EN to also exercise the forward-S-box option.
module tb_aes_inv_sub_bytes;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;
`ifdef AES_INV_SUB_FWD_EN
    logic         encrypt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    aes_inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef AES_INV_SUB_FWD_EN
        .encrypt   (encrypt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        s = inv ^ 8'h63;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s;
    endfunction

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_tbl[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = fwd_tbl[s[8*i +: 8]];
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents s for one cycle; returns at the negedge after the acceptance edge.
    task automatic send(input logic [127:0] s);
        @(negedge clk);
        check("in_ready_idle", {127'b0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_state = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic transact(input string tag, input logic [127:0] s, input logic [127:0] exp);
        int lat;
        send(s);
        wait_done(lat);
        check({tag, "_latency"}, lat, 4);
        check(tag, out_state, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {127'b0, out_valid}, 128'd0);
        check({tag, "_ready_back"}, {127'b0, in_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] exp;
        int lat;

        for (int x = 0; x < 256; x++) fwd_tbl[x] = fwd_sbox_calc(x[7:0]);
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = x[7:0];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_state  = '0;
`ifdef AES_INV_SUB_FWD_EN
        encrypt   = 1'b0;
`endif
        #1;
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_in_ready", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

        transact("vec_seq", 128'h637c777b_f26b6fc5_3001672b_fed7ab76,
                 128'h00010203_04050607_08090a0b_0c0d0e0f);
        transact("vec_zero", 128'h0, {16{8'h52}});
        transact("vec_16", {16{8'h16}}, {16{8'hff}});
        transact("vec_mixed", {{4{8'h63}}, {4{8'h7c}}, {4{8'hed}}, {4{8'h52}}},
                 {{4{8'h00}}, {4{8'h01}}, {4{8'h53}}, {4{8'h48}}});

        // Back-pressure with in_valid toggling through BUSY and DONE.
        out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        exp = model_inv(s);
        send(s);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", {127'b0, out_valid}, 128'd1);
            check("bp_out_state", out_state, exp);
            check("bp_in_ready", {127'b0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {127'b0, out_valid}, 128'd0);
        check("bp_release_ready", {127'b0, in_ready}, 128'd1);

        // Reset during the second BUSY cycle.
        send({16{8'h63}});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {127'b0, out_valid}, 128'd0);
        check("abort_out_state", out_state, 128'd0);
        check("abort_in_ready", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_spurious", {127'b0, out_valid}, 128'd0);
        end
        transact("abort_recover", 128'h0, {16{8'h52}});

        // Every byte value in every word; forward model applied to the output must restore the input.
        for (int k = 0; k < 64; k++) begin
            logic [31:0] w;
            w = {k[5:0], 2'd0, k[5:0], 2'd1, k[5:0], 2'd2, k[5:0], 2'd3};
            s = {4{w}};
            send(s);
            wait_done(lat);
            check("table_latency", lat, 4);
            check("table_out", out_state, model_inv(s));
            check("table_roundtrip", model_fwd(out_state), s);
        end
        @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            transact("random", s, model_inv(s));
        end

`ifdef AES_INV_SUB_FWD_EN
        encrypt = 1'b1;
        send(128'h00010203_04050607_08090a0b_0c0d0e0f);
        encrypt = 1'b0;
        wait_done(lat);
        check("fwd_latency", lat, 4);
        check("fwd_vec", out_state, 128'h637c777b_f26b6fc5_3001672b_fed7ab76);
        s = out_state;
        @(negedge clk);
        transact("fwd_back_inv", s, 128'h00010203_04050607_08090a0b_0c0d0e0f);
        for (int k = 0; k < 8; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            encrypt = 1'b1;
            send(s);
            encrypt = 1'b0;
            wait_done(lat);
            check("fwd_rand", out_state, model_fwd(s));
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
